// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage registered ALU execute unit with valid/ready on both sides.
// Stage 1 captures the operand bundle; stage 2 computes and holds result, zero, br_taken, illegal.
// Ports: clk, rst (async, active-high); in_valid/in_ready with src_a, src_b, alu_ctrl,
//   br_sel, is_branch; out_valid/out_ready with result, zero, br_taken, illegal;
//   op_count counts output handshakes and saturates instead of wrapping.
// Optional macro ALU_EXEC_FLAGS_EN adds registered carry, overflow and negative outputs.
module alu_exec_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_ctrl,
    input  logic             br_sel,
    input  logic             is_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             br_taken,
    output logic             illegal,
`ifdef ALU_EXEC_FLAGS_EN
    output logic             carry,
    output logic             overflow,
    output logic             negative,
`endif
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_ctrl;
    logic             s1_sel;
    logic             s1_br;

    logic s1_advance;
    logic in_fire;
    logic out_fire;

    // S1 may move on whenever S2 is empty or is emptying this cycle.
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;

    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             alu_zero;
    logic             alu_br;
    logic             slt_bit;

`ifdef ALU_EXEC_FLAGS_EN
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           f_c;
    logic           f_o;
    logic           f_n;

    // Sub as a + ~b + 1 so the top bit is directly "no borrow".
    assign add_w = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_w = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_r = add_w[WIDTH-1:0];
    assign sub_r = sub_w[WIDTH-1:0];

    always_comb begin
        f_c = 1'b0;
        f_o = 1'b0;
        f_n = 1'b0;
        case (s1_ctrl)
            OP_ADD: begin
                f_c = add_w[WIDTH];
                f_o = (s1_a[MSB] == s1_b[MSB]) && (add_r[MSB] != s1_a[MSB]);
                f_n = add_r[MSB];
            end
            OP_SUB: begin
                f_c = sub_w[WIDTH];
                f_o = (s1_a[MSB] != s1_b[MSB]) && (sub_r[MSB] != s1_a[MSB]);
                f_n = sub_r[MSB];
            end
            default: begin
                f_c = 1'b0;
                f_o = 1'b0;
                f_n = 1'b0;
            end
        endcase
    end
`else
    assign add_r = s1_a + s1_b;
    assign sub_r = s1_a - s1_b;
`endif

    assign slt_bit = $signed(s1_a) < $signed(s1_b);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (s1_ctrl)
            OP_ADD:  alu_res = add_r;
            OP_SUB:  alu_res = sub_r;
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: alu_ill = 1'b1;
        endcase
    end

    // Illegal codes force result 0, so zero=1 and br_taken still follows it.
    assign alu_zero = (alu_res == '0);
    assign alu_br   = s1_br && (alu_zero ^ s1_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
            s1_sel   <= 1'b0;
            s1_br    <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= src_a;
            s1_b     <= src_b;
            s1_ctrl  <= alu_ctrl;
            s1_sel   <= br_sel;
            s1_br    <= is_branch;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            br_taken  <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_EXEC_FLAGS_EN
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
`endif
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result   <= alu_res;
                zero     <= alu_zero;
                br_taken <= alu_br;
                illegal  <= alu_ill;
`ifdef ALU_EXEC_FLAGS_EN
                carry    <= f_c;
                overflow <= f_o;
                negative <= f_n;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_fire && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Consumes the 3-bit ALU control code and branch-select produced by the control/ALU-decode path and executes it on two operands.
- Two-stage registered execution unit with valid/ready handshakes on both sides; sits between register-read and writeback/branch-resolve.
- Produces result, zero flag, branch-taken decision, an illegal-code indication and a completed-operation counter.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B (register or immediate, already muxed).
- alu_ctrl  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt (signed); all other codes illegal.
- br_sel  input  1  0 = branch-on-equal, 1 = branch-on-not-equal; only meaningful with is_branch.
- is_branch  input  1  bundle is a branch compare.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- br_taken  output  1  is_branch & (zero ^ br_sel).
- illegal  output  1  alu_ctrl was an illegal code.
- op_count  output  CNT_W  number of completed output handshakes, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: in_ready=1 once reset deasserts; out_valid=0, result=0, zero=0, br_taken=0, illegal=0, op_count=0. Both stage valids are cleared.
- Stage 1 (S1): registers src_a, src_b, alu_ctrl, br_sel, is_branch on an input handshake (in_valid & in_ready).
- Stage 2 (S2): computes from the S1 registers and registers result/zero/br_taken/illegal.
- Latency: an accepted bundle drives out_valid 2 cycles after acceptance when there is no backpressure.
- S2 holds when out_valid & !out_ready; all S2 outputs stay stable while holding.
- S1 advances when S2 is empty or S2 completes a handshake in the same cycle.
- in_ready = !s1_valid | s1_advance, a combinational function of registered state and out_ready. No combinational path from in_valid to in_ready.
- Full throughput: one bundle per cycle with out_ready held high.
- Full: both stages valid and out_ready=0. in_ready=0 and no input is lost or overwritten.
- Simultaneous accept and emit: when S2 emits, S1 moves into S2 and a new input loads S1, all in the same cycle.
- Arithmetic: add/sub are modulo 2^WIDTH, carry discarded.
  - slt: 1 if signed(src_a) < signed(src_b), else 0, zero-extended to WIDTH.
  - and/or are bitwise.
- Illegal codes (100, 110, 111): result=0, zero=1, illegal=1. br_taken is still computed from zero.
- op_count increments on each out_valid & out_ready and saturates at 2^CNT_W-1; it does not wrap.
- Reset mid-operation: in-flight bundles are discarded, with no output handshake afterwards and op_count=0.
- Outputs while out_valid=0 are don't-care except out_valid itself and op_count.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- When defined, three extra registered outputs are added, each with reset value 0 and held with the other S2 outputs:
  - carry: carry-out of add; for sub, carry = NOT borrow.
  - overflow: signed overflow of add/sub.
  - negative: result[WIDTH-1].
  - All three are 0 for and/or/slt/illegal codes.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-stream with 2 bundles in flight -> out_valid=0 immediately; op_count=0; no stale output after release; in_ready=1.
- Arithmetic, WIDTH=32: add 0xFFFFFFFF+1 -> result=0, zero=1. sub 5-7 -> 0xFFFFFFFE. slt 0xFFFFFFFF vs 1 -> 1. and 0xF0F0 & 0x0FF0 -> 0x00F0. or -> 0xFFF0.
- Branch: is_branch=1, sub 9-9, br_sel=0 -> br_taken=1; same operands with br_sel=1 -> br_taken=0. 3-9 with br_sel=1 -> br_taken=1.
- Illegal: alu_ctrl=110 -> illegal=1, result=0, zero=1. Next legal add 2+3 -> illegal=0, result=5.
- Backpressure: stream 4 bundles with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted bundles and outputs hold stable. Release -> all 4 results emerge in order, back-to-back, and op_count=4.
- Saturation with CNT_W=4: 20 handshakes -> op_count=15. With ALU_EXEC_FLAGS_EN: add 0x7FFFFFFF+1 -> overflow=1, negative=1, carry=0.
